// File: rtl/alu_operand_stage_if.sv
// Issue, ALU and writeback bundle for alu_operand_stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface alu_operand_stage_if #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [2:0]            issue_op;
    logic [ADDR_WIDTH-1:0] issue_src_a;
    logic [ADDR_WIDTH-1:0] issue_src_b;
    logic                  issue_imm_en;
    logic [DATA_WIDTH-1:0] issue_imm;
    logic [ADDR_WIDTH-1:0] issue_dst;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [2:0]            alu_op_code;
    logic [ADDR_WIDTH-1:0] alu_dst;

    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [3:0]            wb_flags;

    logic [3:0]            flags;
    logic [NUM_REGS-1:0]   pending;

    modport slave (
        input  issue_valid, issue_op, issue_src_a, issue_src_b, issue_imm_en,
               issue_imm, issue_dst, alu_ready, wb_en, wb_addr, wb_data, wb_flags,
        output issue_ready, alu_valid, alu_a, alu_b, alu_op_code, alu_dst,
               flags, pending
    );

    modport master (
        output issue_valid, issue_op, issue_src_a, issue_src_b, issue_imm_en,
               issue_imm, issue_dst, alu_ready, wb_en, wb_addr, wb_data, wb_flags,
        input  issue_ready, alu_valid, alu_a, alu_b, alu_op_code, alu_dst,
               flags, pending
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register file, NZCV flags and pending-write scoreboard ahead of the ALU.
// Define WB_BYPASS_EN to forward same-cycle writeback data to the sources and mask its hazards.
module alu_operand_stage #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [3:0]            flags_q;
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_nxt;

    logic                  alu_valid_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [2:0]            alu_op_q;
    logic [ADDR_WIDTH-1:0] alu_dst_q;

    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;
    logic                  pend_a;
    logic                  pend_b;
    logic                  pend_d;
    logic                  hazard;
    logic                  issue_ready;
    logic                  accept;

`ifdef WB_BYPASS_EN
    logic wb_hit_a;
    logic wb_hit_b;
    logic wb_hit_d;

    always_comb begin
        wb_hit_a = bus.wb_en && (bus.wb_addr == bus.issue_src_a);
        wb_hit_b = bus.wb_en && (bus.wb_addr == bus.issue_src_b);
        wb_hit_d = bus.wb_en && (bus.wb_addr == bus.issue_dst);
        opnd_a   = wb_hit_a ? bus.wb_data : regs[bus.issue_src_a];
        opnd_b   = bus.issue_imm_en ? bus.issue_imm
                 : (wb_hit_b ? bus.wb_data : regs[bus.issue_src_b]);
        pend_a   = pending_q[bus.issue_src_a] && !wb_hit_a;
        pend_b   = pending_q[bus.issue_src_b] && !wb_hit_b;
        pend_d   = pending_q[bus.issue_dst]   && !wb_hit_d;
    end
`else
    // Without forwarding a pending bit stalls even when its writeback lands this cycle.
    always_comb begin
        opnd_a = regs[bus.issue_src_a];
        opnd_b = bus.issue_imm_en ? bus.issue_imm : regs[bus.issue_src_b];
        pend_a = pending_q[bus.issue_src_a];
        pend_b = pending_q[bus.issue_src_b];
        pend_d = pending_q[bus.issue_dst];
    end
`endif

    always_comb begin
        hazard      = pend_a || (!bus.issue_imm_en && pend_b) || pend_d;
        issue_ready = (!alu_valid_q || bus.alu_ready) && !hazard;
        accept      = bus.issue_valid && issue_ready;
    end

    // Clear first so a same-cycle issue to the written register keeps its bit set.
    always_comb begin
        pending_nxt = pending_q;
        if (bus.wb_en) begin
            pending_nxt[bus.wb_addr] = 1'b0;
        end
        if (accept) begin
            pending_nxt[bus.issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            flags_q   <= '0;
            pending_q <= '0;
        end else begin
            if (bus.wb_en) begin
                regs[bus.wb_addr] <= bus.wb_data;
                flags_q           <= bus.wb_flags;
            end
            pending_q <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_dst_q   <= '0;
        end else if (accept) begin
            alu_valid_q <= 1'b1;
            alu_a_q     <= opnd_a;
            alu_b_q     <= opnd_b;
            alu_op_q    <= bus.issue_op;
            alu_dst_q   <= bus.issue_dst;
        end else if (bus.alu_ready) begin
            alu_valid_q <= 1'b0;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.alu_valid   = alu_valid_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op_code = alu_op_q;
    assign bus.alu_dst     = alu_dst_q;
    assign bus.flags       = flags_q;
    assign bus.pending     = pending_q;
endmodule
